spi_ram_cmd: RTL and testbench

Parametrised command-decoded single-port RAM. It sits behind the SPI slave and is the next generation of the 256x8 command RAM. Each accepted frame carries a 2-bit command plus a payload word. The block adds configurable width and depth, a read-data handshake with back-pressure, drop reporting, and optional burst address auto-increment.

---
 rtl/spi_ram_pkg.sv | 18 +
 rtl/spi_ram_array.sv | 39 +++
 rtl/spi_ram_cmd.sv | 147 ++++++++++++++
 tb/tb_spi_ram_cmd.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types for the command-decoded SPI RAM: the 2-bit command codes
// carried in the top bits of each frame and the read-output FSM states.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    // IDLE: no read data outstanding. HOLD: dout carries unconsumed data.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } out_state_e;

endpackage

// File: rtl/spi_ram_array.sv
// Storage for the command RAM: one synchronous write port and a registered
// read port with enable. The read register can be forced to zero so the
// caller can return 0 for out-of-range reads without a separate output mux.
// The stored words themselves are never reset; only the read register is.
module spi_ram_array #(
    parameter int WORD_W    = 8,
    parameter int MEM_DEPTH = 256,
    localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [MEM_DEPTH];

    // Write port: caller only asserts wr_en for in-range indices.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read register: loads on rd_en, cleared by reset so held data is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_idx];
        end
    end

endmodule

// File: rtl/spi_ram_cmd.sv
// Command-decoded single-port RAM behind the SPI slave. Each frame on din
// carries a 2-bit command and a WORD_W payload. Reads are returned on dout
// with a valid/ready handshake:
//   tx_valid=1 means dout holds unconsumed data; a transfer completes at a
//   rising edge where tx_valid=1 and tx_ready=1. While tx_valid=1, dout is
//   stable. A read command arriving while data is held and tx_ready=0 is
//   discarded and reported on rd_drop.
// Optional feature: define SPI_RAM_AUTO_INC_EN to post-increment wr_addr on
// each data write and rd_addr on each accepted data read (wrap at
// MEM_DEPTH-1; out-of-range addresses step upward without wrapping).
module spi_ram_cmd
    import spi_ram_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [WORD_W+1:0] din,
    input  logic              tx_ready,
    output logic [WORD_W-1:0] dout,
    output logic              tx_valid,
    output logic              rd_drop,
    output logic              addr_err
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // Depth as an ADDR_W+1 bit value so range checks compare equal widths.
    localparam logic [ADDR_W:0] DEPTH_C = MEM_DEPTH[ADDR_W:0];

    cmd_e              cmd;
    logic [ADDR_W-1:0] pl_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_cmd;
    logic              rd_cmd;
    logic              rd_accept;
    logic              rd_dropped;
    out_state_e        state_q;
    out_state_e        state_d;

    assign cmd     = cmd_e'(din[WORD_W+1:WORD_W]);
    assign pl_addr = din[ADDR_W-1:0];

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);

    assign wr_cmd = rx_valid && (cmd == CMD_WR_DATA);
    assign rd_cmd = rx_valid && (cmd == CMD_RD_DATA);
    // A read is taken when nothing is held, or the held word leaves this edge.
    assign rd_accept  = rd_cmd && ((state_q == IDLE) || tx_ready);
    assign rd_dropped = rd_cmd && (state_q == HOLD) && !tx_ready;

`ifdef SPI_RAM_AUTO_INC_EN
    localparam logic [ADDR_W:0] LAST_C = DEPTH_C - 1'b1;
    logic [ADDR_W-1:0] wr_addr_inc;
    logic [ADDR_W-1:0] rd_addr_inc;
    // Wrap only from the last valid word; out-of-range addresses keep stepping.
    assign wr_addr_inc = ({1'b0, wr_addr} == LAST_C) ? '0 : wr_addr + 1'b1;
    assign rd_addr_inc = ({1'b0, rd_addr} == LAST_C) ? '0 : rd_addr + 1'b1;
`endif

    // Address registers: explicit loads, plus post-increment when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else begin
            if (rx_valid && (cmd == CMD_WR_ADDR)) begin
                wr_addr <= pl_addr;
            end
`ifdef SPI_RAM_AUTO_INC_EN
            else if (wr_cmd) begin
                wr_addr <= wr_addr_inc;
            end
`endif
            if (rx_valid && (cmd == CMD_RD_ADDR)) begin
                rd_addr <= pl_addr;
            end
`ifdef SPI_RAM_AUTO_INC_EN
            else if (rd_accept) begin
                rd_addr <= rd_addr_inc;
            end
`endif
        end
    end

    spi_ram_array #(
        .WORD_W    (WORD_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_cmd && wr_in_range),
        .wr_idx  (wr_addr[IDX_W-1:0]),
        .wr_data (din[WORD_W-1:0]),
        .rd_en   (rd_accept),
        .rd_zero (!rd_in_range),
        .rd_idx  (rd_addr[IDX_W-1:0]),
        .rd_data (dout)
    );

    // Output FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output FSM next state: load on accepted read, release on handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_accept) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (tx_ready && !rd_cmd) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_valid = (state_q == HOLD);

    // Single-cycle status pulses for the edge that saw the offending command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_drop  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_drop  <= rd_dropped;
            addr_err <= (wr_cmd && !wr_in_range) || (rd_accept && !rd_in_range);
        end
    end

endmodule

// File: tb/tb_spi_ram_cmd.sv
// Bench for spi_ram_cmd: a 256-word instance carries the main vectors and a
// 200-word instance, fed the same inputs, covers out-of-range accesses.
module tb_spi_ram_cmd;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [9:0] din;
    logic       tx_ready;
    logic [7:0] dout;
    logic       tx_valid;
    logic       rd_drop;
    logic       addr_err;
    logic [7:0] dout200;
    logic       tx_valid200;
    logic       rd_drop200;
    logic       addr_err200;

    int n_vec = 0;
    int n_err = 0;

    spi_ram_cmd #(.WORD_W(8), .ADDR_W(8), .MEM_DEPTH(256)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .din      (din),
        .tx_ready (tx_ready),
        .dout     (dout),
        .tx_valid (tx_valid),
        .rd_drop  (rd_drop),
        .addr_err (addr_err)
    );

    spi_ram_cmd #(.WORD_W(8), .ADDR_W(8), .MEM_DEPTH(200)) dut200 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .din      (din),
        .tx_ready (tx_ready),
        .dout     (dout200),
        .tx_valid (tx_valid200),
        .rd_drop  (rd_drop200),
        .addr_err (addr_err200)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rx;
        logic [1:0] cmd;
        logic [7:0] pl;
        logic       rdy;
        logic       e_tv;
        logic [7:0] e_dout;
        logic       e_drop;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string n, input logic rx, input logic [1:0] c,
                                input logic [7:0] p, input logic r, input logic tv,
                                input logic [7:0] d, input logic dr, input logic er);
        vec_t v;
        v.name = n; v.rx = rx; v.cmd = c; v.pl = p; v.rdy = r;
        v.e_tv = tv; v.e_dout = d; v.e_drop = dr; v.e_err = er;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_main(input string name, input logic tv, input logic [7:0] d,
                              input logic dr, input logic er);
        check({name, ".tx_valid"}, {7'd0, tx_valid}, {7'd0, tv});
        check({name, ".dout"}, dout, d);
        check({name, ".rd_drop"}, {7'd0, rd_drop}, {7'd0, dr});
        check({name, ".addr_err"}, {7'd0, addr_err}, {7'd0, er});
    endtask

    // Driver: present one frame, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic rx, input logic [1:0] c, input logic [7:0] p, input logic r);
        rx_valid = rx;
        din      = {c, p};
        tx_ready = r;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    logic [7:0] b2b_exp [4];

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        din      = '0;
        tx_ready = 1'b0;

`ifdef SPI_RAM_AUTO_INC_EN
        b2b_exp[0] = 8'h77; b2b_exp[1] = 8'h78; b2b_exp[2] = 8'h79; b2b_exp[3] = 8'h7A;
`else
        b2b_exp[0] = 8'h77; b2b_exp[1] = 8'h77; b2b_exp[2] = 8'h77; b2b_exp[3] = 8'h77;
`endif

        // Basic write/read and handshake
        add("wa05",  1, 2'b00, 8'h05, 0, 0, 8'h00, 0, 0);
        add("wd05",  1, 2'b01, 8'hA5, 0, 0, 8'h00, 0, 0);
        add("ra05",  1, 2'b10, 8'h05, 0, 0, 8'h00, 0, 0);
        add("rd05",  1, 2'b11, 8'h00, 1, 1, 8'hA5, 0, 0);
        add("ack1",  0, 2'b00, 8'h00, 1, 0, 8'hA5, 0, 0);
        // Back-pressure and drop
        add("wa06",  1, 2'b00, 8'h06, 0, 0, 8'hA5, 0, 0);
        add("wd06",  1, 2'b01, 8'h3C, 0, 0, 8'hA5, 0, 0);
        add("ra05b", 1, 2'b10, 8'h05, 0, 0, 8'hA5, 0, 0);
        add("rd05b", 1, 2'b11, 8'h00, 0, 1, 8'hA5, 0, 0);
        add("ra06h", 1, 2'b10, 8'h06, 0, 1, 8'hA5, 0, 0);
        add("drop",  1, 2'b11, 8'hFF, 0, 1, 8'hA5, 1, 0);
        add("hold",  0, 2'b00, 8'h00, 0, 1, 8'hA5, 0, 0);
        add("ack2",  0, 2'b00, 8'h00, 1, 0, 8'hA5, 0, 0);
        add("rd06",  1, 2'b11, 8'h00, 1, 1, 8'h3C, 0, 0);
        add("ack3",  0, 2'b00, 8'h00, 1, 0, 8'h3C, 0, 0);
        // Write then read of same address on the next cycle
        add("ra20",  1, 2'b10, 8'h20, 0, 0, 8'h3C, 0, 0);
        add("wa20",  1, 2'b00, 8'h20, 0, 0, 8'h3C, 0, 0);
        add("wd20",  1, 2'b01, 8'h5A, 0, 0, 8'h3C, 0, 0);
        add("rd20",  1, 2'b11, 8'h00, 1, 1, 8'h5A, 0, 0);
        add("ack4",  0, 2'b00, 8'h00, 1, 0, 8'h5A, 0, 0);
        // Back-to-back reads with tx_ready held high
        for (int i = 0; i < 4; i++) begin
            add($sformatf("b2b_wa%0d", i), 1, 2'b00, 8'h10 + 8'(i), 0, 0, 8'h5A, 0, 0);
            add($sformatf("b2b_wd%0d", i), 1, 2'b01, 8'h77 + 8'(i), 0, 0, 8'h5A, 0, 0);
        end
        add("b2b_ra", 1, 2'b10, 8'h10, 1, 0, 8'h5A, 0, 0);
        for (int i = 0; i < 4; i++) begin
            add($sformatf("b2b_rd%0d", i), 1, 2'b11, 8'h00, 1, 1, b2b_exp[i], 0, 0);
        end
        add("b2b_ack", 0, 2'b00, 8'h00, 1, 0, b2b_exp[3], 0, 0);

        // Reset values
        #12;
        check_main("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        foreach (vecs[i]) begin
            step(vecs[i].rx, vecs[i].cmd, vecs[i].pl, vecs[i].rdy);
            check_main(vecs[i].name, vecs[i].e_tv, vecs[i].e_dout, vecs[i].e_drop, vecs[i].e_err);
        end

        // Out-of-range on the 200-word instance; 256-word instance stays clean
        step(1, 2'b00, 8'hC8, 0);
        check("oor_wa.err200", {7'd0, addr_err200}, 8'd0);
        step(1, 2'b01, 8'h99, 0);
        check("oor_wd.err200", {7'd0, addr_err200}, 8'd1);
        check("oor_wd.err256", {7'd0, addr_err}, 8'd0);
        step(0, 2'b00, 8'h00, 0);
        check("oor_idle.err200", {7'd0, addr_err200}, 8'd0);
        step(1, 2'b10, 8'hC8, 0);
        check("oor_ra.err200", {7'd0, addr_err200}, 8'd0);
        step(1, 2'b11, 8'h00, 1);
        check("oor_rd.tv200", {7'd0, tx_valid200}, 8'd1);
        check("oor_rd.dout200", dout200, 8'h00);
        check("oor_rd.err200", {7'd0, addr_err200}, 8'd1);
        check("oor_rd.dout256", dout, 8'h99);
        check("oor_rd.err256", {7'd0, addr_err}, 8'd0);
        step(0, 2'b00, 8'h00, 1);
        check("oor_ack.tv200", {7'd0, tx_valid200}, 8'd0);
        check("oor_ack.err200", {7'd0, addr_err200}, 8'd0);
        step(1, 2'b10, 8'h05, 1);
        step(1, 2'b11, 8'h00, 1);
        check("oor_intact.dout200", dout200, 8'hA5);
        step(0, 2'b00, 8'h00, 1);

        // Write across the top of the 256-word space and read back
`ifdef SPI_RAM_AUTO_INC_EN
        step(1, 2'b00, 8'hFE, 0);
        step(1, 2'b01, 8'h11, 0);
        step(1, 2'b01, 8'h22, 0);
        step(1, 2'b01, 8'h33, 0);
        step(1, 2'b10, 8'hFE, 1);
        step(1, 2'b11, 8'h00, 1);
        check("wrap_rdFE", dout, 8'h11);
        step(1, 2'b11, 8'h00, 1);
        check("wrap_rdFF", dout, 8'h22);
        step(1, 2'b11, 8'h00, 1);
        check("wrap_rd00", dout, 8'h33);
        check("wrap_tv", {7'd0, tx_valid}, 8'd1);
`else
        step(1, 2'b00, 8'hFE, 0);
        step(1, 2'b01, 8'h11, 0);
        step(1, 2'b00, 8'hFF, 0);
        step(1, 2'b01, 8'h22, 0);
        step(1, 2'b00, 8'h00, 0);
        step(1, 2'b01, 8'h33, 0);
        step(1, 2'b10, 8'hFE, 1);
        step(1, 2'b11, 8'h00, 1);
        check("wrap_rdFE", dout, 8'h11);
        step(1, 2'b10, 8'hFF, 1);
        step(1, 2'b11, 8'h00, 1);
        check("wrap_rdFF", dout, 8'h22);
        step(1, 2'b10, 8'h00, 1);
        step(1, 2'b11, 8'h00, 1);
        check("wrap_rd00", dout, 8'h33);
        check("wrap_tv", {7'd0, tx_valid}, 8'd1);
`endif
        step(0, 2'b00, 8'h00, 1);
        check("wrap_ack", {7'd0, tx_valid}, 8'd0);

        // Asynchronous reset while data is held
        step(1, 2'b10, 8'h05, 0);
        step(1, 2'b11, 8'h00, 0);
        check("prerst.tv", {7'd0, tx_valid}, 8'd1);
        check("prerst.dout", dout, 8'hA5);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.tv", {7'd0, tx_valid}, 8'd0);
        check("rst.dout", dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 2'b10, 8'h05, 1);
        step(1, 2'b11, 8'h00, 1);
        check("postrst.dout", dout, 8'hA5);
        check("postrst.tv", {7'd0, tx_valid}, 8'd1);
        step(0, 2'b00, 8'h00, 1);
        check("postrst.ack", {7'd0, tx_valid}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
